// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//   Two-requester round-robin arbiter that drives the select line of a
//   downstream 2:1 mux. A grant window lasts up to HOLD_CYCLES cycles. When
//   a window ends, the other requester takes over with no idle bubble if it
//   is requesting. If only the owner is still requesting, the owner gets a
//   fresh window.
//
// Parameters
//   HOLD_CYCLES : maximum consecutive cycles of one grant window (1..15)
//   CNT_W       : width of the hold counter
//
// Ports
//   clk    : clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   req_a  : request for mux input a
//   req_b  : request for mux input b
//   sel    : registered mux select (0 = a, 1 = b); holds its value while idle
//   gnt_a  : registered, a owns the mux
//   gnt_b  : registered, b owns the mux
//   valid  : registered, gnt_a | gnt_b
//   last   : registered, final cycle of the current hold window
// ---------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic valid,
  output logic last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  // Set when b was granted most recently, so an idle tie goes to a.
  logic             r_rr_b;
  logic             w_rr_b_nxt;
  logic             w_new_win;
  logic             w_at_max;
  logic             r_sel;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_valid;
  logic             r_last;
  logic             w_sel_nxt;

  assign w_at_max = (r_cnt == CNT_MAX);

  // Next-state, hold-counter and round-robin pointer computation.
  always_comb begin
    w_state_nxt = r_state;
    w_new_win   = 1'b0;
    case (r_state)
      IDLE: begin
        w_new_win = req_a | req_b;
        if (req_a && req_b) begin
          w_state_nxt = r_rr_b ? GNT_A : GNT_B;
        end else if (req_a) begin
          w_state_nxt = GNT_A;
        end else if (req_b) begin
          w_state_nxt = GNT_B;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT_A: begin
        if (!req_a || w_at_max) begin
          // The other requester wins at window end. Otherwise the owner
          // regrants, or the arbiter falls back to idle.
          w_new_win = req_a | req_b;
          if (req_b) begin
            w_state_nxt = GNT_B;
          end else if (req_a) begin
            w_state_nxt = GNT_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = GNT_A;
        end
      end
      GNT_B: begin
        if (!req_b || w_at_max) begin
          w_new_win = req_a | req_b;
          if (req_a) begin
            w_state_nxt = GNT_A;
          end else if (req_b) begin
            w_state_nxt = GNT_B;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = GNT_B;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_new_win   = 1'b0;
      end
    endcase

    // The counter restarts on every window entry and cannot pass CNT_MAX,
    // because reaching CNT_MAX always ends the window.
    if (w_new_win || (w_state_nxt == IDLE)) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    if (w_new_win) begin
      w_rr_b_nxt = (w_state_nxt == GNT_B);
    end else begin
      w_rr_b_nxt = r_rr_b;
    end

    // sel follows ownership and holds its value through idle to avoid a mux glitch.
    if (w_state_nxt == GNT_A) begin
      w_sel_nxt = 1'b0;
    end else if (w_state_nxt == GNT_B) begin
      w_sel_nxt = 1'b1;
    end else begin
      w_sel_nxt = r_sel;
    end
  end

  // State, counter, pointer and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_rr_b  <= 1'b1;
      r_sel   <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rr_b  <= w_rr_b_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt_a <= (w_state_nxt == GNT_A);
      r_gnt_b <= (w_state_nxt == GNT_B);
      r_valid <= (w_state_nxt != IDLE);
      r_last  <= (w_state_nxt != IDLE) && (w_cnt_nxt == CNT_MAX);
    end
  end

  assign sel   = r_sel;
  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign valid = r_valid;
  assign last  = r_last;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mux_sel_arbiter. It runs two instances on shared stimulus:
// one with HOLD_CYCLES = 4 and one with HOLD_CYCLES = 1. Each stimulus cycle
// pushes the predicted outputs of both instances into queues. A monitor pops
// and compares them one clock edge later. Scenario tasks also run their own
// directed checks.
// ---------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  logic clk;
  logic rst_n;
  logic req_a;
  logic req_b;
  logic sel0, gnt_a0, gnt_b0, valid0, last0;
  logic sel1, gnt_a1, gnt_b1, valid1, last1;

  int n_checks = 0;
  int n_fail   = 0;

  // {gnt_a, gnt_b, valid, last, sel}
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  // Reference model state per instance: own 0=none 1=a 2=b; ptr = last granted
  int   m_own[2];
  int   m_cnt[2];
  int   m_ptr[2];
  logic m_sel[2];
  int   m_h[2];

  mux_sel_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .sel(sel0), .gnt_a(gnt_a0), .gnt_b(gnt_b0), .valid(valid0), .last(last0)
  );

  mux_sel_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .sel(sel1), .gnt_a(gnt_a1), .gnt_b(gnt_b1), .valid(valid1), .last(last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0;
      m_cnt[i] = 0;
      m_ptr[i] = 2;
      m_sel[i] = 1'b0;
    end
  endfunction

  function automatic logic [4:0] model_next(input int i, input logic a, input logic b);
    int  own;
    int  nown;
    bit  ending;
    own    = m_own[i];
    ending = (own == 0) || (m_cnt[i] == m_h[i] - 1) || (own == 1 && !a) || (own == 2 && !b);
    if (!ending) begin
      nown     = own;
      m_cnt[i] = m_cnt[i] + 1;
    end else begin
      if (own == 1)      nown = b ? 2 : (a ? 1 : 0);
      else if (own == 2) nown = a ? 1 : (b ? 2 : 0);
      else if (a && b)   nown = (m_ptr[i] == 2) ? 1 : 2;
      else if (a)        nown = 1;
      else if (b)        nown = 2;
      else               nown = 0;
      m_cnt[i] = 0;
      if (nown != 0) m_ptr[i] = nown;
    end
    m_own[i] = nown;
    if (nown == 1) m_sel[i] = 1'b0;
    if (nown == 2) m_sel[i] = 1'b1;
    return {nown == 1, nown == 2, nown != 0, (nown != 0) && (m_cnt[i] == m_h[i] - 1), m_sel[i]};
  endfunction

  // Scoreboard monitor: compare the queued predictions just after each rising edge.
  always @(posedge clk) begin
    logic [4:0] exp_v;
    #1;
    if (q0.size() > 0) begin
      exp_v = q0.pop_front();
      n_checks++;
      if ({gnt_a0, gnt_b0, valid0, last0, sel0} !== exp_v) begin
        n_fail++;
        $display("FAIL sb_hold4 t=%0t got %b exp %b ({gnt_a,gnt_b,valid,last,sel})",
                 $time, {gnt_a0, gnt_b0, valid0, last0, sel0}, exp_v);
      end
    end
    if (q1.size() > 0) begin
      exp_v = q1.pop_front();
      n_checks++;
      if ({gnt_a1, gnt_b1, valid1, last1, sel1} !== exp_v) begin
        n_fail++;
        $display("FAIL sb_hold1 t=%0t got %b exp %b ({gnt_a,gnt_b,valid,last,sel})",
                 $time, {gnt_a1, gnt_b1, valid1, last1, sel1}, exp_v);
      end
    end
    n_checks++;
    if ((gnt_a0 && gnt_b0) || (gnt_a1 && gnt_b1)) begin
      n_fail++;
      $display("FAIL mutex t=%0t got gnt0=%b%b gnt1=%b%b exp no double grant",
               $time, gnt_a0, gnt_b0, gnt_a1, gnt_b1);
    end
  end

  // Drive one cycle of requests, predict the outputs, then wait past the edge.
  task automatic step(input logic a, input logic b);
    @(negedge clk);
    req_a = a;
    req_b = b;
    q0.push_back(model_next(0, a, b));
    q1.push_back(model_next(1, a, b));
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if ({gnt_a0, gnt_b0, valid0, last0, sel0, gnt_a1, gnt_b1, valid1, last1, sel1} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0000000000",
               {gnt_a0, gnt_b0, valid0, last0, sel0, gnt_a1, gnt_b1, valid1, last1, sel1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hold_regrant();
    int n_gnt  = 0;
    int n_last = 0;
    int n_sel  = 0;
    for (int k = 0; k < 11; k++) begin
      step(1'b1, 1'b0);
      if (gnt_a0) n_gnt++;
      if (last0)  n_last++;
      if (sel0)   n_sel++;
    end
    n_checks++;
    if (n_gnt != 11 || n_last != 2 || n_sel != 0) begin
      n_fail++;
      $display("FAIL hold_regrant got gnt=%0d last=%0d sel1=%0d exp 11 2 0", n_gnt, n_last, n_sel);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [11:0] seen_a;
    logic [11:0] seen_b;
    logic [11:0] seen_v;
    logic [11:0] seen_s;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1);
      seen_a[k] = gnt_a0;
      seen_b[k] = gnt_b0;
      seen_v[k] = valid0;
      seen_s[k] = sel0;
    end
    n_checks++;
    if (seen_a !== 12'hF0F || seen_b !== 12'h0F0 || seen_v !== 12'hFFF || seen_s !== 12'h0F0) begin
      n_fail++;
      $display("FAIL round_robin got a=%h b=%h v=%h s=%h exp F0F 0F0 FFF 0F0",
               seen_a, seen_b, seen_v, seen_s);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_hold_one();
    logic [7:0] seen_a;
    logic [7:0] seen_b;
    logic [7:0] seen_l;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1);
      seen_a[k] = gnt_a1;
      seen_b[k] = gnt_b1;
      seen_l[k] = last1;
    end
    n_checks++;
    if (seen_a !== 8'h55 || seen_b !== 8'hAA || seen_l !== 8'hFF) begin
      n_fail++;
      $display("FAIL hold_one got a=%h b=%h last=%h exp 55 AA FF", seen_a, seen_b, seen_l);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_drop_handover();
    logic l3;
    apply_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_checks++;
    if ({gnt_a0, gnt_b0, sel0, last0} !== 4'b0110) begin
      n_fail++;
      $display("FAIL drop_handover got {a,b,sel,last}=%b exp 0110", {gnt_a0, gnt_b0, sel0, last0});
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    l3 = last0;
    step(1'b0, 1'b1);
    n_checks++;
    if ({l3, last0, gnt_b0} !== 3'b011) begin
      n_fail++;
      $display("FAIL cnt_restart got {last@3,last@4,gnt_b}=%b exp 011", {l3, last0, gnt_b0});
    end
  endtask

  task automatic test_idle_hold_sel();
    step(1'b0, 1'b0);
    n_checks++;
    if ({valid0, last0, sel0, gnt_b0} !== 4'b0010) begin
      n_fail++;
      $display("FAIL idle_hold_sel got {valid,last,sel,gnt_b}=%b exp 0010", {valid0, last0, sel0, gnt_b0});
    end
  endtask

  task automatic test_reset_mid_window();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({gnt_a0, gnt_b0, valid0, last0, sel0} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_window got %b exp 00000", {gnt_a0, gnt_b0, valid0, last0, sel0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    n_checks++;
    if ({gnt_a0, gnt_b0, sel0} !== 3'b100) begin
      n_fail++;
      $display("FAIL first_tie_after_reset got {a,b,sel}=%b exp 100", {gnt_a0, gnt_b0, sel0});
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    step(1'b0, 1'b0);
  endtask

  initial begin
    m_h[0] = 4;
    m_h[1] = 1;
    test_reset();
    test_hold_regrant();
    test_round_robin();
    test_hold_one();
    test_drop_handover();
    test_idle_hold_sel();
    test_reset_mid_window();
    test_random();
    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
